// File: rtl/ho_pkg.sv
// ho_pkg: types, constants and small helpers shared by the handover controller.
package ho_pkg;

  localparam int N_BS     = 3;
  localparam int SQ_W_DEF = 8;

  typedef logic [1:0] bs_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SELECT,
    OFFER,
    RELEASE,
    NOTIFY,
    FAIL
  } ho_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_BS-1:0] bs_onehot(input bs_idx_t idx);
    return N_BS'(1) << idx;
  endfunction

  // Next base-station index, wrapping modulo N_BS.
  function automatic bs_idx_t bs_next(input bs_idx_t idx);
    return (idx >= bs_idx_t'(N_BS - 1)) ? '0 : idx + bs_idx_t'(1);
  endfunction

endpackage

// File: rtl/ho_rr_arbiter.sv
// ho_rr_arbiter: 3-way round-robin pick; the first requester at or after ptr wins.
module ho_rr_arbiter
  import ho_pkg::*;
(
  input  logic [N_BS-1:0] req,
  input  bs_idx_t         ptr,
  output bs_idx_t         idx
);

  logic    w_found;
  bs_idx_t w_cand;

  // Walk the requesters starting at ptr, wrapping around, and keep the first hit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    idx     = '0;
    w_found = 1'b0;
    w_cand  = ptr;
    for (int k = 0; k < N_BS; k++) begin
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
      w_cand = bs_next(w_cand);
    end
  end

endmodule

// File: rtl/handover_controller.sv
// handover_controller: moves a device from a weak source BS to the best other BS,
// offering the target, waiting for its ack with a timeout, then releasing the source.
module handover_controller
  import ho_pkg::*;
#(
  parameter int SQ_W        = SQ_W_DEF,
  parameter int SQ_THRESH   = 50,
  parameter int SQ_HYST     = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_BS-1:0]        bs_req,
  input  logic [N_BS*SQ_W-1:0]   dm_sq,
  input  logic [N_BS-1:0]        bs_ack,
  output logic [N_BS-1:0]        bs_grant,
  output logic [N_BS-1:0]        bs_target,
  output logic [N_BS-1:0]        bs_release,
  output logic [1:0]             sv_target,
  output logic                   sv_valid,
  output logic                   fail,
  output logic                   busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // Quality compares are done one bit wider so src + hysteresis cannot wrap.
  typedef logic [SQ_W:0] sq_ext_t;
  localparam sq_ext_t THRESH_X = sq_ext_t'(SQ_THRESH);
  localparam sq_ext_t HYST_X   = sq_ext_t'(SQ_HYST);

  ho_state_t                   r_state;
  ho_state_t                   w_next_state;
  bs_idx_t                     r_rr_ptr;
  bs_idx_t                     r_src;
  bs_idx_t                     r_best;
  logic [CNT_W-1:0]            r_cnt;
  logic [N_BS-1:0][SQ_W-1:0]   r_sq;

  bs_idx_t                     w_arb_idx;
  bs_idx_t                     w_best;
  logic [SQ_W-1:0]             w_best_sq;
  logic                        w_found;
  sq_ext_t                     w_src_need;
  logic                        w_offer_ok;

  ho_rr_arbiter u_arb (
    .req (bs_req),
    .ptr (r_rr_ptr),
    .idx (w_arb_idx)
  );

  // Argmax of the snapshot over every BS except the source; strict '>' keeps ties on the lower index.
  always_comb begin
    w_best    = '0;
    w_best_sq = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N_BS; i++) begin
      if (bs_idx_t'(i) != r_src && (!w_found || r_sq[i] > w_best_sq)) begin
        w_best    = bs_idx_t'(i);
        w_best_sq = r_sq[i];
        w_found   = 1'b1;
      end
    end
  end

  assign w_src_need = {1'b0, r_sq[r_src]} + HYST_X;
  assign w_offer_ok = ({1'b0, w_best_sq} >= THRESH_X) && ({1'b0, w_best_sq} >= w_src_need);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
    if (reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Handover context: the source is latched as ARB is entered so its grant is a plain
  // decode of registered values; quality is snapshotted while in ARB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_src    <= '0;
      r_best   <= '0;
      r_cnt    <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset like any other register.
      r_sq     <= '0;
    end else begin
      case (r_state)
        IDLE:         if (|bs_req) r_src <= w_arb_idx;
        ARB:          r_sq <= dm_sq;
        SELECT: begin
          r_best <= w_best;
          r_cnt  <= '0;
        end
        OFFER:        r_cnt <= r_cnt + CNT_W'(1);
        NOTIFY, FAIL: r_rr_ptr <= bs_next(r_src);
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_next_state = r_state;
    bs_grant     = '0;
    bs_target    = '0;
    bs_release   = '0;
    sv_target    = '0;
    sv_valid     = 1'b0;
    fail         = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:    if (|bs_req) w_next_state = ARB;
      ARB: begin
        bs_grant     = bs_onehot(r_src);
        w_next_state = SELECT;
      end
      SELECT:  w_next_state = w_offer_ok ? OFFER : FAIL;
      OFFER: begin
        bs_target = bs_onehot(r_best);
        // The target's ack takes priority over an expiring timeout.
        if (bs_ack[r_best])         w_next_state = RELEASE;
        else if (r_cnt == CNT_LAST) w_next_state = FAIL;
      end
      RELEASE: begin
        bs_release   = bs_onehot(r_src);
        w_next_state = NOTIFY;
      end
      NOTIFY: begin
        sv_target    = r_best;
        sv_valid     = 1'b1;
        w_next_state = IDLE;
      end
      FAIL: begin
        fail         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_handover_controller.sv
// tb_handover_controller: directed scenarios plus randomized handovers checked against
// a behavioural model of the handover rules.
module tb_handover_controller;

  localparam int TMO    = 16;
  localparam int THRESH = 50;
  localparam int HYST   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  bs_req;
  logic [23:0] dm_sq;
  logic [2:0]  bs_ack;
  logic [2:0]  bs_grant;
  logic [2:0]  bs_target;
  logic [2:0]  bs_release;
  logic [1:0]  sv_target;
  logic        sv_valid;
  logic        fail;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_rr  = 0;

  typedef struct {
    int src;
    int best;
    bit sel_ok;
    bit success;
  } exp_t;

  typedef struct {
    int         grant_obs;
    int         grant_cnt;
    logic [2:0] grant_val;
    logic [2:0] target_or;
    int         target_cyc;
    int         target_first;
    logic [2:0] release_val;
    int         release_cnt;
    int         release_obs;
    int         sv_obs;
    int         sv_cnt;
    logic [1:0] sv_tgt;
    int         fail_obs;
    int         fail_cnt;
    int         onehot_bad;
    int         done_obs;
  } rec_t;

  exp_t ex;
  rec_t rc;

  handover_controller dut (
    .clk        (clk),
    .reset      (reset),
    .bs_req     (bs_req),
    .dm_sq      (dm_sq),
    .bs_ack     (bs_ack),
    .bs_grant   (bs_grant),
    .bs_target  (bs_target),
    .bs_release (bs_release),
    .sv_target  (sv_target),
    .sv_valid   (sv_valid),
    .fail       (fail),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] oh(input int i);
    return 3'(1 << i);
  endfunction

  // Reference: round-robin source, best other BS (ties low), threshold + margin, ack vs timeout.
  function automatic exp_t model(input logic [2:0] req, input int rr,
                                 input int q0, input int q1, input int q2, input int d);
    exp_t e;
    int   q [3];
    bit   found;
    q[0] = q0; q[1] = q1; q[2] = q2;
    e.src = 0;
    found = 0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[(rr + k) % 3]) begin
        e.src = (rr + k) % 3;
        found = 1;
      end
    end
    e.best = -1;
    for (int i = 0; i < 3; i++) begin
      if (i != e.src) begin
        if (e.best < 0) e.best = i;
        else if (q[i] > q[e.best]) e.best = i;
      end
    end
    e.sel_ok  = (q[e.best] >= THRESH) && (q[e.best] >= q[e.src] + HYST);
    e.success = e.sel_ok && (d < TMO);
    return e;
  endfunction

  // Drive one handover from IDLE and record every output until busy drops.
  // ack_d = number of OFFER cycles that pass before the target acks.
  task automatic run_handover(input logic [2:0] req, input int q0, input int q1, input int q2,
                              input int ack_d, input bit hold);
    bit finished;
    ex       = model(req, mdl_rr, q0, q1, q2, ack_d);
    rc       = '{default: 0};
    finished = 0;
    bs_req   = req;
    dm_sq    = {8'(q2), 8'(q1), 8'(q0)};
    bs_ack   = '0;
    for (int obs = 1; obs <= 60 && !finished; obs++) begin
      @(posedge clk); #1;
      if (bs_grant != 3'b0) begin
        if (rc.grant_cnt == 0) rc.grant_obs = obs;
        rc.grant_val = bs_grant;
        rc.grant_cnt++;
      end
      if ($countones(bs_grant) > 1 || $countones(bs_target) > 1 || $countones(bs_release) > 1)
        rc.onehot_bad++;
      if (bs_target != 3'b0) begin
        if (rc.target_cyc == 0) rc.target_first = obs;
        rc.target_or = rc.target_or | bs_target;
        rc.target_cyc++;
      end
      if (bs_release != 3'b0) begin
        rc.release_val = bs_release;
        rc.release_obs = obs;
        rc.release_cnt++;
      end
      if (sv_valid) begin
        rc.sv_obs = obs;
        rc.sv_tgt = sv_target;
        rc.sv_cnt++;
      end
      if (fail) begin
        rc.fail_obs = obs;
        rc.fail_cnt++;
      end
      if (!busy) begin
        rc.done_obs = obs;
        finished    = 1;
      end
      // After the snapshot: drop the request and scramble quality; neither may matter.
      if (obs == 2) begin
        if (!hold) bs_req = '0;
        dm_sq = 24'($urandom);
      end
      bs_ack = 3'($urandom) & ~oh(ex.best);
      if (bs_target != 3'b0 && rc.target_cyc - 1 == ack_d) bs_ack = bs_ack | oh(ex.best);
    end
    bs_ack = '0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL handover_budget: busy still %b after 60 cycles, required 0", busy);
    end
    mdl_rr = (ex.src + 1) % 3;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bs_req = '0;
    dm_sq  = '0;
    bs_ack = '0;
    #3;
    n_tests++;
    if ({bs_grant, bs_target, bs_release, sv_target, sv_valid, fail, busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {bs_grant, bs_target, bs_release, sv_target, sv_valid, fail, busy});
    end
    bs_req = 3'b111;
    @(posedge clk); #1;
    n_tests++;
    if ({bs_grant, busy} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b busy=%b, required 000/0", bs_grant, busy);
    end
    bs_req = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
    mdl_rr = 0;
  endtask

  task automatic test_rr_order();
    int order [3];
    int q [3];
    order = '{0, 1, 2};
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) q[j] = (j == order[i]) ? 20 : 80;
      run_handover(3'b111, q[0], q[1], q[2], i, 1'b1);
      n_tests++;
      if (rc.grant_val !== oh(order[i]) || rc.sv_cnt != 1) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: grant=%b sv_pulses=%0d, required grant=%b sv_pulses=1",
                 i, rc.grant_val, rc.sv_cnt, oh(order[i]));
      end
    end
    bs_req = '0;
  endtask

  task automatic test_handover_ok();
    run_handover(3'b001, 30, 80, 60, 2, 1'b0);
    n_tests++;
    if (rc.grant_val !== 3'b001 || rc.grant_obs != 1) begin
      n_fail++;
      $display("FAIL ok_grant: %b at cycle %0d, required 001 at cycle 1", rc.grant_val, rc.grant_obs);
    end
    n_tests++;
    if (rc.target_or !== 3'b010 || rc.target_cyc != 3) begin
      n_fail++;
      $display("FAIL ok_target: %b for %0d cycles, required 010 for 3", rc.target_or, rc.target_cyc);
    end
    n_tests++;
    if (rc.release_val !== 3'b001 || rc.release_cnt != 1) begin
      n_fail++;
      $display("FAIL ok_release: %b x%0d, required 001 x1", rc.release_val, rc.release_cnt);
    end
    n_tests++;
    if (rc.sv_tgt !== 2'd1 || rc.sv_cnt != 1 || rc.sv_obs != 7 || rc.fail_cnt != 0) begin
      n_fail++;
      $display("FAIL ok_notify: sv_target=%0d pulses=%0d cycle=%0d fails=%0d, required 1/1/7/0",
               rc.sv_tgt, rc.sv_cnt, rc.sv_obs, rc.fail_cnt);
    end
  endtask

  task automatic test_below_thresh();
    run_handover(3'b001, 30, 34, 40, 0, 1'b0);
    n_tests++;
    if (rc.fail_cnt != 1 || rc.fail_obs != 3 || rc.target_cyc != 0 || rc.sv_cnt != 0) begin
      n_fail++;
      $display("FAIL below_thresh: fails=%0d at %0d target_cycles=%0d sv=%0d, required 1 at 3, 0, 0",
               rc.fail_cnt, rc.fail_obs, rc.target_cyc, rc.sv_cnt);
    end
  endtask

  task automatic test_tie_timeout();
    run_handover(3'b010, 70, 20, 70, 100, 1'b0);
    n_tests++;
    if (rc.grant_val !== 3'b010 || rc.target_or !== 3'b001) begin
      n_fail++;
      $display("FAIL tie_target: grant=%b target=%b, required 010/001", rc.grant_val, rc.target_or);
    end
    n_tests++;
    if (rc.target_cyc != TMO || rc.fail_cnt != 1 || rc.fail_obs != 3 + TMO || rc.release_cnt != 0) begin
      n_fail++;
      $display("FAIL tie_timeout: offer=%0d fails=%0d at %0d releases=%0d, required %0d 1 at %0d 0",
               rc.target_cyc, rc.fail_cnt, rc.fail_obs, rc.release_cnt, TMO, 3 + TMO);
    end
  endtask

  task automatic test_ack_on_timeout();
    run_handover(3'b100, 90, 10, 20, TMO - 1, 1'b0);
    n_tests++;
    if (rc.release_val !== 3'b100 || rc.fail_cnt != 0 || rc.sv_cnt != 1 || rc.sv_obs != 4 + TMO) begin
      n_fail++;
      $display("FAIL ack_on_timeout: release=%b fails=%0d sv=%0d at %0d, required 100 0 1 at %0d",
               rc.release_val, rc.fail_cnt, rc.sv_cnt, rc.sv_obs, 4 + TMO);
    end
  endtask

  task automatic test_reset_in_offer();
    bit found;
    run_handover(3'b001, 10, 90, 0, 0, 1'b0);
    bs_req = 3'b001;
    dm_sq  = {8'd0, 8'd90, 8'd10};
    bs_ack = '0;
    found  = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(posedge clk); #1;
      if (c == 1) bs_req = '0;
      if (bs_target != 3'b0) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL offer_reached: bs_target=%b, required nonzero within 8 cycles", bs_target);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bs_target !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_offer: target=%b busy=%b, required 000/0", bs_target, busy);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b, required 0", busy);
    end
    mdl_rr = 0;
    run_handover(3'b111, 20, 80, 80, 1, 1'b0);
    n_tests++;
    if (rc.grant_val !== 3'b001 || rc.sv_cnt != 1) begin
      n_fail++;
      $display("FAIL rr_after_reset: grant=%b sv=%0d, required 001/1", rc.grant_val, rc.sv_cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0] req;
    int q0, q1, q2, d, e_tcyc, e_end;
    for (int it = 0; it < 40; it++) begin
      req = 3'($urandom_range(1, 7));
      q0  = $urandom_range(0, 120);
      q1  = $urandom_range(0, 120);
      q2  = $urandom_range(0, 120);
      d   = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
      run_handover(req, q0, q1, q2, d, 1'b0);
      e_tcyc = !ex.sel_ok ? 0 : (ex.success ? d + 1 : TMO);
      e_end  = ex.success ? 5 + d : (ex.sel_ok ? 3 + TMO : 3);
      n_tests++;
      if (rc.grant_val !== oh(ex.src) || rc.grant_obs != 1 || rc.grant_cnt != 1) begin
        n_fail++;
        $display("FAIL rnd%0d grant: %b at %0d x%0d, required %b at 1 x1",
                 it, rc.grant_val, rc.grant_obs, rc.grant_cnt, oh(ex.src));
      end
      n_tests++;
      if (rc.target_or !== (ex.sel_ok ? oh(ex.best) : 3'b000) || rc.target_cyc != e_tcyc ||
          (e_tcyc != 0 && rc.target_first != 3)) begin
        n_fail++;
        $display("FAIL rnd%0d target: %b for %0d from %0d, required %b for %0d from 3",
                 it, rc.target_or, rc.target_cyc, rc.target_first,
                 ex.sel_ok ? oh(ex.best) : 3'b000, e_tcyc);
      end
      n_tests++;
      if (rc.release_cnt != (ex.success ? 1 : 0) ||
          (ex.success && (rc.release_val !== oh(ex.src) || rc.release_obs != e_end - 1))) begin
        n_fail++;
        $display("FAIL rnd%0d release: %b x%0d at %0d, required %b x%0d at %0d",
                 it, rc.release_val, rc.release_cnt, rc.release_obs, oh(ex.src),
                 ex.success ? 1 : 0, e_end - 1);
      end
      n_tests++;
      if (rc.sv_cnt != (ex.success ? 1 : 0) ||
          (ex.success && (rc.sv_tgt !== 2'(ex.best) || rc.sv_obs != e_end))) begin
        n_fail++;
        $display("FAIL rnd%0d notify: sv=%0d x%0d at %0d, required %0d x%0d at %0d",
                 it, rc.sv_tgt, rc.sv_cnt, rc.sv_obs, ex.best, ex.success ? 1 : 0, e_end);
      end
      n_tests++;
      if (rc.fail_cnt != (ex.success ? 0 : 1) || (!ex.success && rc.fail_obs != e_end)) begin
        n_fail++;
        $display("FAIL rnd%0d abort: x%0d at %0d, required x%0d at %0d",
                 it, rc.fail_cnt, rc.fail_obs, ex.success ? 0 : 1, e_end);
      end
      n_tests++;
      if (rc.done_obs != e_end + 1 || rc.onehot_bad != 0) begin
        n_fail++;
        $display("FAIL rnd%0d idle: busy dropped at %0d multi-hot=%0d, required %0d and 0",
                 it, rc.done_obs, rc.onehot_bad, e_end + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_handover_ok();
    test_below_thresh();
    test_tie_timeout();
    test_ack_on_timeout();
    test_reset_in_offer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
